stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
Timekeeping stage directly downstream of the button/switch debouncer in the lab3 stopwatch. Consumes debounced PAUSE, RESET, ADJ and SEL, and keeps a MM:SS count as BCD digits. Drives per-field blink flags for the 7-segment display driver that follows it. Contains its own tick divider, pause toggle logic, normal/adjust counting modes and blink phase.

Parameters:
DIV_Q, 25_000_000, clk cycles per quarter-second tick (tick4); the bench overrides it to 4.

Ports:
clk  in  1  system clock (100 MHz on board)
rst_n  in  1  synchronous, active-low reset; one clock; all state is clocked on posedge clk
PAUSE  in  1  debounced pause button level; the rising edge toggles paused
RESET  in  1  debounced clear button level; active-high soft clear
ADJ  in  1  1 = adjust mode
SEL  in  1  adjust field select: 0 = minutes, 1 = seconds
min_tens  out  3  minutes tens digit, 0-5
min_ones  out  4  minutes ones digit, 0-9
sec_tens  out  3  seconds tens digit, 0-5
sec_ones  out  4  seconds ones digit, 0-9
paused  out  1  current pause state
blink_min  out  1  minutes field blanking phase
blink_sec  out  1  seconds field blanking phase

Behaviour:
- rst_n=0 at a clock edge: all digits 0, paused=0, divider=0, phase q=0, pause_q=0. All outputs read 0 the cycle after.
- Divider: counts 0..DIV_Q-1 and wraps. tick4 is high for one cycle when count==DIV_Q-1.
- Phase q[1:0] increments on tick4.
  - tick2 = tick4 & q[0]==1.
  - tick1 = tick4 & q==3.
- Divider and phase are free-running and not gated by paused.
- RESET=1 (level): clears digits to 00:00, paused, divider and q.
  - Overrides every other event in that cycle, including a PAUSE rise and any tick.
- Pause edge detect: pause_q <= PAUSE every cycle, including while RESET=1.
  - rise = PAUSE & ~pause_q. On rise, paused toggles at the next edge.
  - A level held high toggles paused exactly once.
  - PAUSE already high when rst_n releases counts as one rise.
- paused=1 blocks all digit updates. Ticks still occur but are ignored.
- Normal mode (ADJ=0, paused=0), on tick1, updating one cycle after tick1:
  - seconds +1; 59 → 00 with minutes +1.
  - minutes 59 → 00, so 59:59 → 00:00.
- Adjust mode (ADJ=1, paused=0), on tick2:
  - The field chosen by SEL increments mod 60, with no carry into the other field.
  - The other field holds. tick1 has no effect.
- ADJ and SEL are sampled in the tick cycle; a mode change takes effect immediately and does not disturb divider phase.
- Digit arithmetic is BCD: ones 9 → 0 increments tens; tens 5 with ones 9 → 00. Out-of-range codes are never produced.
- Blink outputs (combinational from registers):
  - blink_min = ADJ & ~SEL & q[0].
  - blink_sec = ADJ & SEL & q[0].
  - The selected field toggles every DIV_Q cycles; both flags are 0 when ADJ=0. Blink continues while paused.
- paused output is the registered pause state.

Decomposition:
- stopwatch_pkg holds:
  - MAX_TENS=5, MAX_ONES=9
  - digit widths 3/4
  - the BCD increment-mod-60 function used by both fields (returns next value and carry).
- One sub-module, tick_gen: the divider plus q. Its ports are clk, rst_n, clr (=RESET), tick1, tick2, tick4 and q.
- Counting and pause logic stay in stopwatch_core.

Test Plan:
All tests use DIV_Q=4, so tick4 fires every 4 cycles, tick2 every 8 and tick1 every 16.
1. rst_n=0 for 2 cycles, then ADJ=0 and 960 cycles -> all outputs 0 after reset; reads 01:00 after 60 tick1, with seconds stepping every 16 cycles.
2. Adjust to 59:59, set ADJ=0, next tick1 -> 00:00 with digits 0/0/0/0; no intermediate illegal BCD codes (checked every cycle).
3. One PAUSE pulse -> paused=1 one cycle after the rise and digits frozen for 64 cycles. A second pulse -> paused=0 and counting resumes. PAUSE held 100 cycles -> exactly one toggle.
4. From 00:58, set ADJ=1, SEL=1 -> 00:59 after the next tick2, then 00:00 with min_ones still 0. blink_sec toggles every 4 cycles and blink_min stays 0. Switch SEL=0 -> minutes step on tick2.
5. RESET=1 in the same cycle as a PAUSE rise at 03:27 running -> 00:00, paused=0, q=0. The next tick1 arrives 16 cycles after RESET drops.
6. rst_n=0 mid-adjust at 12:34 with paused=1 -> all digits 0, paused=0 and blink flags 0 on the next cycle, even with ADJ still 1 while q=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared digit widths, BCD limits and the mod-60 BCD increment used by both MM and SS fields.
// Pure definitions: no state, no latency, no backpressure.
package stopwatch_pkg;

  localparam int TENS_W = 3;
  localparam int ONES_W = 4;

  localparam logic [TENS_W-1:0] MAX_TENS = 3'd5;
  localparam logic [ONES_W-1:0] MAX_ONES = 4'd9;

  typedef struct packed {
    logic [TENS_W-1:0] tens;
    logic [ONES_W-1:0] ones;
  } bcd60_t;

  typedef struct packed {
    bcd60_t val;
    logic   carry;
  } bcd60_inc_t;

  // 59 wraps to 00 with carry; codes outside 00..59 are never produced from legal inputs.
  function automatic bcd60_inc_t bcd60_inc(input bcd60_t cur);
    bcd60_inc_t r;
    r.val   = cur;
    r.carry = 1'b0;
    if (cur.ones != MAX_ONES) begin
      r.val.ones = cur.ones + 4'd1;
    end else begin
      r.val.ones = '0;
      if (cur.tens != MAX_TENS) begin
        r.val.tens = cur.tens + 3'd1;
      end else begin
        r.val.tens = '0;
        r.carry    = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// Free-running quarter-second divider plus 2-bit phase; emits 4 Hz, 2 Hz and 1 Hz strobes.
// Strobes are combinational from registers (zero latency); no backpressure, clr restarts the phase.
module tick_gen #(
  parameter int DIV_Q = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  output logic       tick1,
  output logic       tick2,
  output logic       tick4,
  output logic [1:0] q
);

  localparam int CW = (DIV_Q > 1) ? $clog2(DIV_Q) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_Q - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
      q   <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      q   <= q + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick4 = (cnt == LAST);
  assign tick2 = tick4 & q[0];
  assign tick1 = tick4 & (q == 2'd3);

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with pause toggle, normal/adjust counting and field blink flags.
// Digits update one cycle after the tick; no backpressure, RESET level overrides all events.
module stopwatch_core #(
  parameter int DIV_Q = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PAUSE,
  input  logic       RESET,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic       blink_min,
  output logic       blink_sec
);
  import stopwatch_pkg::*;

  logic       tick1, tick2, tick4;
  logic [1:0] phase;
  logic       phase_unused;

  bcd60_t     min_r, sec_r;
  bcd60_inc_t min_inc, sec_inc;
  logic       paused_r, pause_q, pause_rise;

  tick_gen #(.DIV_Q(DIV_Q)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (RESET),
    .tick1 (tick1),
    .tick2 (tick2),
    .tick4 (tick4),
    .q     (phase)
  );

  // Only the 2 Hz bit of the phase drives the display; tick4 is implied by tick1/tick2.
  assign phase_unused = phase[1] ^ tick4;

  assign min_inc    = bcd60_inc(min_r);
  assign sec_inc    = bcd60_inc(sec_r);
  assign pause_rise = PAUSE & ~pause_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_r    <= '0;
      sec_r    <= '0;
      paused_r <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      // Edge history keeps tracking during RESET so a held button cannot re-toggle after clear.
      pause_q <= PAUSE;
      if (RESET) begin
        min_r    <= '0;
        sec_r    <= '0;
        paused_r <= 1'b0;
      end else begin
        if (pause_rise) paused_r <= ~paused_r;
        if (!paused_r) begin
          if (!ADJ && tick1) begin
            sec_r <= sec_inc.val;
            if (sec_inc.carry) min_r <= min_inc.val;
          end else if (ADJ && tick2) begin
            if (SEL) sec_r <= sec_inc.val;
            else     min_r <= min_inc.val;
          end
        end
      end
    end
  end

  assign min_tens  = min_r.tens;
  assign min_ones  = min_r.ones;
  assign sec_tens  = sec_r.tens;
  assign sec_ones  = sec_r.ones;
  assign paused    = paused_r;
  assign blink_min = ADJ & ~SEL & phase[0];
  assign blink_sec = ADJ & SEL & phase[0];

endmodule

// File: tb/tb_stopwatch_core.sv
// Stopwatch bench: directed scenarios plus random input soak, checked every cycle against
// a cycle-count/integer-minutes-seconds reference model.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       PAUSE = 1'b0, RESET = 1'b0, ADJ = 1'b0, SEL = 1'b0;
  logic [2:0] min_tens, sec_tens;
  logic [3:0] min_ones, sec_ones;
  logic       paused, blink_min, blink_sec;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since last clear (mod 16), minutes, seconds, pause state.
  int n = 0, mm = 0, ss = 0;
  bit pm = 0, pq = 0;

  stopwatch_core #(.DIV_Q(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PAUSE     (PAUSE),
    .RESET     (RESET),
    .ADJ       (ADJ),
    .SEL       (SEL),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .paused    (paused),
    .blink_min (blink_min),
    .blink_sec (blink_sec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit rise, t1, t2, ph;
    if (!rst_n) begin
      n = 0; mm = 0; ss = 0; pm = 0; pq = 0;
    end else begin
      rise = PAUSE && !pq;
      pq   = PAUSE;
      t2   = (n % 8) == 7;
      t1   = (n % 16) == 15;
      if (RESET) begin
        n = 0; mm = 0; ss = 0; pm = 0;
      end else begin
        n = (n + 1) % 16;
        if (!pm) begin
          if (!ADJ && t1) begin
            ss = ss + 1;
            if (ss == 60) begin ss = 0; mm = (mm + 1) % 60; end
          end else if (ADJ && t2) begin
            if (SEL) ss = (ss + 1) % 60;
            else     mm = (mm + 1) % 60;
          end
        end
        if (rise) pm = !pm;
      end
    end
    @(posedge clk);
    #1;
    ph = ((n / 4) % 2) == 1;
    chk("min_tens", 8'(min_tens), 8'(mm / 10));
    chk("min_ones", 8'(min_ones), 8'(mm % 10));
    chk("sec_tens", 8'(sec_tens), 8'(ss / 10));
    chk("sec_ones", 8'(sec_ones), 8'(ss % 10));
    chk("paused", 8'(paused), 8'(pm));
    chk("blink_min", 8'(blink_min), 8'(ADJ && !SEL && ph));
    chk("blink_sec", 8'(blink_sec), 8'(ADJ && SEL && ph));
    chk("bcd_legal", 8'(min_tens <= 5 && min_ones <= 9 && sec_tens <= 5 && sec_ones <= 9), 8'd1);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic adjust_to(input int m, input int s);
    int guard;
    ADJ = 1'b1; SEL = 1'b0; guard = 0;
    while (mm != m && guard < 1000) begin step(); guard++; end
    chk("adj_reach_min", 8'(min_tens * 10 + min_ones), 8'(m));
    SEL = 1'b1; guard = 0;
    while (ss != s && guard < 1000) begin step(); guard++; end
    chk("adj_reach_sec", 8'(sec_tens * 10 + sec_ones), 8'(s));
  endtask

  initial begin
    bit p0;
    int cnt;

    // 1: reset, then one minute of normal counting
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1; ADJ = 1'b0;
    run(16);
    chk("first_second", 8'(sec_ones), 8'd1);
    run(944);
    chk("one_minute_mo", 8'(min_ones), 8'd1);
    chk("one_minute_s", 8'(sec_tens * 10 + sec_ones), 8'd0);

    // 2: 59:59 rolls to 00:00
    adjust_to(59, 59);
    ADJ = 1'b0;
    cnt = 0;
    while (ss != 0 && cnt < 40) begin step(); cnt++; end
    chk("wrap_all_zero", {min_tens, min_ones[3:0], 1'b0} | 8'(sec_tens) | 8'(sec_ones), 8'd0);

    // 3: pause pulse, freeze, resume, held level toggles once
    run(20);
    PAUSE = 1'b1; step();
    chk("pause_on", 8'(paused), 8'd1);
    PAUSE = 1'b0;
    p0 = 0;
    cnt = sec_tens * 10 + sec_ones;
    run(64);
    chk("frozen", 8'(sec_tens * 10 + sec_ones), 8'(cnt));
    PAUSE = 1'b1; step(); PAUSE = 1'b0;
    chk("pause_off", 8'(paused), 8'd0);
    run(40);
    p0 = paused;
    PAUSE = 1'b1; run(100); PAUSE = 1'b0; step();
    chk("held_one_toggle", 8'(paused), 8'(!p0));
    PAUSE = 1'b1; step(); PAUSE = 1'b0; run(3);

    // 4: adjust seconds from 00:58, then minutes
    RESET = 1'b1; step(); RESET = 1'b0;
    adjust_to(0, 58);
    run(24);
    chk("adj_sec_wrap_min", 8'(min_ones), 8'd0);
    SEL = 1'b0;
    run(16);

    // 5: RESET coincident with a PAUSE rise while running at 03:27
    adjust_to(3, 27);
    ADJ = 1'b0;
    run(5);
    PAUSE = 1'b1; RESET = 1'b1; step();
    chk("rst_pause_ignored", 8'(paused), 8'd0);
    RESET = 1'b0; PAUSE = 1'b0;
    cnt = 0;
    while (sec_ones == 0 && cnt < 40) begin step(); cnt++; end
    chk("tick1_after_reset", 8'(cnt), 8'd16);

    // 6: synchronous reset while adjusting and paused
    adjust_to(12, 34);
    PAUSE = 1'b1; step(); PAUSE = 1'b0; run(3);
    chk("paused_at_1234", 8'(paused), 8'd1);
    rst_n = 1'b0; SEL = 1'b0; step();
    chk("rst_blink_min", 8'(blink_min), 8'd0);
    rst_n = 1'b1; ADJ = 1'b0;
    run(10);

    // Random soak
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) < 10) PAUSE = ~PAUSE;
      if ($urandom_range(99) < 5)  ADJ = ~ADJ;
      if ($urandom_range(99) < 5)  SEL = ~SEL;
      RESET = ($urandom_range(99) < 2);
      rst_n = !($urandom_range(199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
